ram_arbiter: RTL
================

# ram_arbiter

Shares the single-port program/data RAM of the K-and-S processor between two requesters: the CPU datapath port (instruction fetch, LOAD, STORE) and an external port used for program loading and debug inspection. Each transaction is arbitrated, latched, sequenced through the RAM's one-cycle synchronous read, and then acknowledged. The block sits between the datapath/control unit memory signals and the RAM instance.

## Interface
Parameters:
- ADDR_W, default 5: RAM address width.
- DATA_W, default 16: RAM data width.
- CPU_PRIORITY, default 0: 0 selects round-robin; 1 selects fixed priority, CPU first.

Ports (all widths in bits):
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- cpu_req, input, 1: CPU transaction request.
- cpu_we, input, 1: 1 = write, 0 = read.
- cpu_addr, input, ADDR_W: CPU address.
- cpu_wdata, input, DATA_W: CPU write data.
- cpu_ack, output, 1: one-cycle completion pulse.
- cpu_rdata, output, DATA_W: registered read data.
- ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rdata: same directions, widths and meaning as the CPU port.
- ram_addr, output, ADDR_W: RAM address.
- ram_wdata, output, DATA_W: RAM write data.
- ram_we, output, 1: RAM write strobe.
- ram_rdata, input, DATA_W: RAM read data, valid one cycle after the address is presented.
- busy, output, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate among asserted requests. On a winner, latch winner id, we, addr and wdata, then go to ACCESS. With no request, stay in IDLE.
  - ACCESS: drive ram_addr from the latched address. For a write, also drive ram_wdata and assert ram_we, then go to RESP. For a read, go to READ_WAIT.
  - READ_WAIT: keep driving ram_addr. At the end of the cycle, capture ram_rdata into the winner's rdata register, then go to RESP.
  - RESP: assert the winner's ack for exactly one cycle, then go to IDLE.
- Arbitration:
  - Only one request asserted: that port wins.
  - Both asserted, CPU_PRIORITY=0: the port not granted last wins. The last_grant register resets to EXT, so the CPU wins the first tie.
  - Both asserted, CPU_PRIORITY=1: the CPU always wins.
  - last_grant updates on every grant.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack.
  - Inputs are sampled only in IDLE. Changes during ACCESS, READ_WAIT or RESP have no effect.
  - req still high in the IDLE cycle after ack is a new transaction (back-to-back).
- Output rules:
  - rdata registers change only on a read completing for that port. They hold their value otherwise, including across the other port's transactions.
  - ram_addr and ram_wdata are 0 in IDLE and RESP.
  - ram_we is high only in ACCESS of a write.

## Timing
- Reset (rst_n low, any state, including mid-transaction):
  - state=IDLE, last_grant=EXT.
  - All acks 0, ram_we 0, ram_addr 0, ram_wdata 0, busy 0.
  - cpu_rdata and ext_rdata = 0.
  - The in-flight transaction is dropped with no ack and no RAM write. After release, requesters re-issue.
- Cycle n is the IDLE cycle in which req is sampled.
- Write: ram_we high in n+1, ack in n+2. The next grant is possible in n+3.
- Read: address presented in n+1 and n+2, data captured at the end of n+2, ack in n+3 with rdata valid.
- Sustained throughput for alternating CPU/EXT requests:
  - Writes: one transaction per 3 cycles.
  - Reads: one transaction per 4 cycles.
- With CPU_PRIORITY=0, a waiting requester is granted within one competing transaction (no starvation).

## Structure
- Add to k_and_s_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_READ_WAIT, ARB_RESP}.
  - typedef enum logic arb_port_t {PORT_CPU, PORT_EXT}.
- Sub-module ram_arbiter_pick: combinational. Inputs cpu_req, ext_req, last_grant, CPU_PRIORITY. Outputs grant_valid and grant_port.
- ram_arbiter owns the FSM, the latched request fields, last_grant and the two rdata registers.

## Test plan
- Reset mid-read: assert rst_n low during READ_WAIT. Required: all outputs 0 asynchronously, no ack, and after release IDLE with busy=0.
- Single CPU write then read: write addr 5'h0A, data 16'hBEEF. Required: ram_we high in n+1 only, cpu_ack in n+2. Then read 5'h0A: cpu_ack in n+3 with cpu_rdata=16'hBEEF.
- Simultaneous requests, CPU_PRIORITY=0, both held continuously: grants alternate CPU, EXT, CPU, EXT. Each ack appears only on the granted port.
- Simultaneous requests, CPU_PRIORITY=1: CPU granted every time while cpu_req stays high. EXT is granted only in an IDLE cycle with cpu_req=0.
- Isolation: EXT reads 16'h1234 from addr 3, then the CPU reads 16'h5678 from addr 4. Required: ext_rdata stays 16'h1234 throughout the CPU transaction.
- Input change after grant: change cpu_addr and cpu_we during ACCESS. Required: the RAM sees the originally latched address and operation.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S processor memory subsystem.
// Holds the RAM arbiter FSM states and the requester port identifiers.
package k_and_s_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_READ_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        PORT_CPU,
        PORT_EXT
    } arb_port_t;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Grant selection between the CPU and EXT requesters (round-robin or CPU-first).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is consumed.
module ram_arbiter_pick
    import k_and_s_pkg::*;
#(
    parameter int CPU_PRIORITY = 0
) (
    input  logic      cpu_req,
    input  logic      ext_req,
    input  arb_port_t last_grant,
    output logic      grant_valid,
    output arb_port_t grant_port
);

    always_comb begin
        grant_valid = cpu_req | ext_req;
        grant_port  = PORT_CPU;
        if (cpu_req && ext_req) begin
            if (CPU_PRIORITY != 0)
                grant_port = PORT_CPU;
            else
                grant_port = (last_grant == PORT_CPU) ? PORT_EXT : PORT_CPU;
        end else if (ext_req) begin
            grant_port = PORT_EXT;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between CPU and EXT requesters, one transaction at a time.
// Latency: write acks 2 cycles after the IDLE sample cycle, read acks 3 cycles after.
// Backpressure: requesters hold req until ack; requests are sampled only in IDLE.
module ram_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 16,
    parameter int CPU_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef struct packed {
        arb_port_t         port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    arb_state_t state, state_nxt;
    arb_port_t  last_grant;
    arb_port_t  grant_port;
    logic       grant_valid;
    req_t       req_q, req_sel;

    ram_arbiter_pick #(
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_pick (
        .cpu_req     (cpu_req),
        .ext_req     (ext_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        if (grant_port == PORT_CPU)
            req_sel = '{port: PORT_CPU, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        else
            req_sel = '{port: PORT_EXT, we: ext_we, addr: ext_addr, wdata: ext_wdata};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:      if (grant_valid) state_nxt = ARB_ACCESS;
            ARB_ACCESS:    state_nxt = req_q.we ? ARB_RESP : ARB_READ_WAIT;
            ARB_READ_WAIT: state_nxt = ARB_RESP;
            ARB_RESP:      state_nxt = ARB_IDLE;
            default:       state_nxt = ARB_IDLE;
        endcase
    end

    // Reset drops any in-flight transaction: all outputs decode from state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= PORT_EXT;
            req_q      <= '0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && grant_valid) begin
                req_q      <= req_sel;
                last_grant <= grant_port;
            end
            if (state == ARB_READ_WAIT) begin
                if (req_q.port == PORT_CPU)
                    cpu_rdata <= ram_rdata;
                else
                    ext_rdata <= ram_rdata;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        cpu_ack   = 1'b0;
        ext_ack   = 1'b0;
        busy      = (state != ARB_IDLE);
        case (state)
            ARB_ACCESS: begin
                ram_addr = req_q.addr;
                if (req_q.we) begin
                    ram_wdata = req_q.wdata;
                    ram_we    = 1'b1;
                end
            end
            ARB_READ_WAIT: ram_addr = req_q.addr;
            ARB_RESP: begin
                cpu_ack = (req_q.port == PORT_CPU);
                ext_ack = (req_q.port == PORT_EXT);
            end
            default: ;
        endcase
    end

endmodule
